// File: rtl/alu_pkg.sv
// Shared op-code encodings, alu_op field values and FSM state type for the ALU execute unit.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_MOV  = 4'b0101;
    localparam logic [3:0] OP_SWAP = 4'b0110;
    localparam logic [3:0] OP_CMP  = 4'b0111;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam logic [1:0] ALU_OP_RTYPE = 2'b11;
    localparam logic [1:0] ALU_OP_CMP   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of {alu_op, funct} into the unit's 4-bit operation and an illegal-funct flag.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int FUNCT_W = 4
) (
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [3:0]         op,
    output logic               illegal
);

    logic funct_hi_nz;

    // Any set bit above the 4-bit function field makes an R-type encoding unknown.
    generate
        if (FUNCT_W > 4) begin : g_wide
            assign funct_hi_nz = |funct[FUNCT_W-1:4];
        end else begin : g_narrow
            assign funct_hi_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        op      = OP_NOP;
        illegal = 1'b0;
        if (alu_op == ALU_OP_CMP) begin
            op = OP_CMP;
        end else if (alu_op == ALU_OP_RTYPE) begin
            if (funct_hi_nz) begin
                illegal = 1'b1;
            end else begin
                case (funct[3:0])
                    4'b0000: op = OP_ADD;
                    4'b0010: op = OP_SUB;
                    4'b0100: op = OP_MUL;
                    4'b0101: op = OP_DIV;
                    4'b0111: op = OP_MOV;
                    4'b1000: op = OP_SWAP;
                    default: illegal = 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: single-cycle add/sub/move/swap/compare, iterative shift-add multiply and
// restoring divide sharing one adder, with valid/ready handshakes on both sides.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int FUNCT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic [3:0]         op_code,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               flag_dz,
    output logic               flag_illegal
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [3:0]         op_q, op_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               dz_q, dz_d;
    logic               ill_q, ill_d;

    logic [3:0]         dec_op;
    logic               dec_illegal;
    logic               accept;
    logic               needs_iter;
    logic [WIDTH:0]     add_x, add_y;
    logic               add_cin;
    logic [WIDTH+1:0]   add_sum;

    alu_op_decode #(.FUNCT_W(FUNCT_W)) u_decode (
        .alu_op  (alu_op),
        .funct   (funct),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    assign accept     = in_valid && (state_q == ST_IDLE);
    assign needs_iter = (dec_op == OP_MUL) || ((dec_op == OP_DIV) && (b != '0));

    // One adder serves add/sub/cmp at accept, the multiply accumulate and the divide trial subtract.
    always_comb begin
        add_x   = {1'b0, a};
        add_y   = {1'b0, b};
        add_cin = 1'b0;
        if (state_q == ST_CALC) begin
            if (op_q == OP_MUL) begin
                add_x = {1'b0, acc_hi_q};
                add_y = {1'b0, opnd_q};
            end else begin
                add_x   = {acc_hi_q, acc_lo_q[WIDTH-1]};
                add_y   = ~{1'b0, opnd_q};
                add_cin = 1'b1;
            end
        end else if ((dec_op == OP_SUB) || (dec_op == OP_CMP)) begin
            add_y   = ~{1'b0, b};
            add_cin = 1'b1;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = needs_iter ? ST_CALC : ST_DONE;
            ST_CALC: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        op_d     = op_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        dz_d     = dz_q;
        ill_d    = ill_q;
        if (accept) begin
            op_d     = dec_op;
            ill_d    = dec_illegal;
            opnd_d   = (dec_op == OP_DIV) ? b : a;
            cnt_d    = CNT_W'(WIDTH);
            carry_d  = 1'b0;
            dz_d     = 1'b0;
            acc_hi_d = '0;
            acc_lo_d = '0;
            case (dec_op)
                OP_ADD: begin
                    acc_lo_d = add_sum[WIDTH-1:0];
                    carry_d  = add_sum[WIDTH];
                end
                OP_SUB, OP_CMP: begin
                    acc_lo_d = add_sum[WIDTH-1:0];
                    carry_d  = ~add_sum[WIDTH+1];
                end
                OP_MUL: acc_lo_d = b;
                OP_DIV: begin
                    if (b == '0) begin
                        acc_lo_d = '1;
                        acc_hi_d = a;
                        dz_d     = 1'b1;
                    end else begin
                        acc_lo_d = a;
                    end
                end
                OP_MOV:  acc_lo_d = b;
                OP_SWAP: begin
                    acc_lo_d = b;
                    acc_hi_d = a;
                end
                default: ;
            endcase
        end else if (state_q == ST_CALC) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q == OP_MUL) begin
                if (acc_lo_q[0]) begin
                    {acc_hi_d, acc_lo_d} = {add_sum[WIDTH:0], acc_lo_q[WIDTH-1:1]};
                end else begin
                    {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
                end
            end else if (add_sum[WIDTH+1]) begin
                // Carry out of the trial subtract means the shifted remainder covers the divisor.
                acc_hi_d = add_sum[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end
        if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
            zero_d = (acc_lo_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            op_q     <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            op_q     <= op_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            dz_q     <= dz_d;
            ill_q    <= ill_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign result       = acc_lo_q;
    assign result_hi    = acc_hi_q;
    assign op_code      = op_q;
    assign flag_zero    = zero_q;
    assign flag_carry   = carry_q;
    assign flag_dz      = dz_q;
    assign flag_illegal = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vectors plus randomized traffic checked every cycle against an arithmetic model.
module tb_alu_exec_unit;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    alu_op = 2'b00;
    logic [3:0]    funct = 4'h0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result, result_hi;
    logic [3:0]    op_code;
    logic          flag_zero, flag_carry, flag_dz, flag_illegal;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_mode = 2;   // 0 random, 1 held low, 2 held high

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [3:0]   op;
        logic [3:0]   flags;  // {zero, carry, dz, illegal}
        int           lat;
    } exp_t;

    alu_exec_unit #(.WIDTH(W), .FUNCT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .op_code(op_code),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_dz(flag_dz), .flag_illegal(flag_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] aop, input logic [3:0] f,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [W:0]     s;
        logic [2*W-1:0] p;
        e.res = '0; e.hi = '0; e.op = 4'hF; e.lat = 1;
        e.flags = 4'b0000;
        if (aop == 2'b10) begin
            e.op = 4'h7; e.res = x - y; e.flags[2] = (x < y);
        end else if (aop == 2'b11) begin
            case (f)
                4'h0: begin s = {1'b0, x} + {1'b0, y}; e.op = 4'h1; e.res = s[W-1:0]; e.flags[2] = s[W]; end
                4'h2: begin e.op = 4'h2; e.res = x - y; e.flags[2] = (x < y); end
                4'h4: begin
                    p = (2*W)'(x) * (2*W)'(y);
                    e.op = 4'h3; e.res = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = W + 1;
                end
                4'h5: begin
                    e.op = 4'h4;
                    if (y == 0) begin e.res = '1; e.hi = x; e.flags[1] = 1'b1; end
                    else begin e.res = x / y; e.hi = x % y; e.lat = W + 1; end
                end
                4'h7: begin e.op = 4'h5; e.res = y; end
                4'h8: begin e.op = 4'h6; e.res = y; e.hi = x; end
                default: e.flags[0] = 1'b1;
            endcase
        end
        e.flags[3] = (e.res == 0);
        return e;
    endfunction

    // Ready generator: changes just after the rising edge so it is stable at every check point.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = 1'b0;
                2:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Scoreboard: predicts handshake signals and retiring results cycle by cycle.
    initial begin
        bit   busy = 0;
        int   vcyc = 0;
        bit   exp_ov;
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            exp_ov = busy && (cyc >= vcyc);
            chk("in_ready", in_ready, !busy);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                chk("result", result, e.res);
                chk("result_hi", result_hi, e.hi);
                chk("op_code", op_code, e.op);
                chk("flags", {flag_zero, flag_carry, flag_dz, flag_illegal}, e.flags);
            end
            if (rst) busy = 0;
            else if (in_valid && !busy) begin
                e = model(alu_op, funct, a, b);
                busy = 1;
                vcyc = cyc + e.lat;
            end else if (exp_ov && out_ready) busy = 0;
        end
    end

    task automatic issue(input logic [1:0] aop, input logic [3:0] f,
                         input logic [W-1:0] x, input logic [W-1:0] y, output int acc_cyc);
        int t = 0;
        while (in_ready !== 1'b1) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                n_checks++; n_fail++;
                $display("FAIL issue_timeout: in_ready stuck low");
                acc_cyc = cyc;
                return;
            end
        end
        alu_op = aop; funct = f; a = x; b = y; in_valid = 1'b1;
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
    endtask

    // Waits for retire; while the unit is busy, throws junk requests at it that must be ignored.
    task automatic wait_retire(output int first_ov, output logic [W-1:0] r,
                               output logic [W-1:0] h, output logic [3:0] fl);
        first_ov = -1; r = '0; h = '0; fl = '0;
        for (int t = 0; t < 300; t++) begin
            if (!in_ready) begin
                in_valid = 1'($urandom_range(0, 1));
                alu_op = 2'($urandom); funct = 4'($urandom);
                a = W'($urandom); b = W'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid && first_ov < 0) begin
                first_ov = cyc; r = result; h = result_hi;
                fl = {flag_zero, flag_carry, flag_dz, flag_illegal};
            end
            if (out_valid && out_ready) begin
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++; n_fail++;
        $display("FAIL retire_timeout: no handshake within bound");
    endtask

    initial begin
        int            acc, fov;
        logic [W-1:0]  r, h;
        logic [3:0]    fl;
        exp_t          e;

        repeat (3) @(negedge clk);
        chk("rst_result", result, 16'h0000);
        chk("rst_result_hi", result_hi, 16'h0000);
        chk("rst_op_code", op_code, 4'h0);
        chk("rst_flags", {flag_zero, flag_carry, flag_dz, flag_illegal}, 4'b0000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        e = model(2'b11, 4'h4, 16'h012C, 16'h012C);
        chk("model_mul", {e.hi, e.res}, 32'h0001_5F90);
        e = model(2'b11, 4'h5, 16'h03E8, 16'h0007);
        chk("model_div", {e.hi, e.res}, 32'h0006_008E);
        e = model(2'b11, 4'h0, 16'hFFFF, 16'h0001);
        chk("model_add_flags", e.flags, 4'b1100);

        ready_mode = 2;
        issue(2'b11, 4'h0, 16'hFFFF, 16'h0001, acc); wait_retire(fov, r, h, fl);
        $display("add  FFFF+0001 -> %h flags %b latency %0d", r, fl, fov - acc);
        chk("add_latency", fov - acc, 1);
        chk("add_result", r, 16'h0000);
        chk("add_flags", fl, 4'b1100);

        issue(2'b11, 4'h4, 16'h012C, 16'h012C, acc); wait_retire(fov, r, h, fl);
        $display("mul  012C*012C -> %h_%h latency %0d", h, r, fov - acc);
        chk("mul_latency", fov - acc, 17);
        chk("mul_result", {h, r}, 32'h0001_5F90);

        issue(2'b11, 4'h5, 16'h03E8, 16'h0007, acc); wait_retire(fov, r, h, fl);
        $display("div  03E8/0007 -> q %h r %h latency %0d", r, h, fov - acc);
        chk("div_result", {h, r}, 32'h0006_008E);
        chk("div_latency", fov - acc, 17);

        issue(2'b11, 4'h5, 16'h5A5A, 16'h0000, acc); wait_retire(fov, r, h, fl);
        $display("div0 5A5A/0000 -> %h_%h flags %b latency %0d", h, r, fl, fov - acc);
        chk("div0_result", {h, r}, 32'h5A5A_FFFF);
        chk("div0_flags", fl, 4'b0010);
        chk("div0_latency", fov - acc, 1);

        ready_mode = 1;
        issue(2'b11, 4'h8, 16'h1234, 16'hABCD, acc);
        for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("swap_hold", {result_hi, result, 7'b0, in_ready}, {16'h1234, 16'hABCD, 8'h00});
            @(negedge clk);
        end
        ready_mode = 2;
        wait_retire(fov, r, h, fl);
        $display("swap 1234/ABCD -> %h_%h after hold", h, r);
        chk("swap_retire", {h, r}, 32'h1234_ABCD);

        issue(2'b11, 4'h3, 16'h1111, 16'h2222, acc); wait_retire(fov, r, h, fl);
        $display("illegal funct 3 -> %h flags %b", r, fl);
        chk("illegal", {r, fl}, {16'h0000, 4'b1001});
        issue(2'b01, 4'h0, 16'h1111, 16'h2222, acc); wait_retire(fov, r, h, fl);
        $display("nop alu_op 01 -> %h flags %b", r, fl);
        chk("nop", {r, fl}, {16'h0000, 4'b1000});

        issue(2'b11, 4'h4, 16'h00FF, 16'h0F0F, acc);
        while (cyc < acc + 8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("mul aborted by reset at cycle %0d", cyc);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        issue(2'b11, 4'h0, 16'h1000, 16'h2345, acc); wait_retire(fov, r, h, fl);
        chk("post_abort_add", {r, fl}, {16'h3345, 4'b0000});

        ready_mode = 0;
        for (int i = 0; i < 300; i++) begin
            logic [1:0] aop;
            logic [3:0] f;
            logic [W-1:0] x, y;
            aop = ($urandom_range(0, 9) < 7) ? 2'b11 : 2'($urandom);
            case ($urandom_range(0, 7))
                0: f = 4'h0; 1: f = 4'h2; 2: f = 4'h4; 3: f = 4'h5;
                4: f = 4'h7; 5: f = 4'h8; 6: f = 4'($urandom); default: f = 4'h5;
            endcase
            x = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
            if ($urandom_range(0, 9) == 0) y = W'($urandom_range(1, 15));
            issue(aop, f, x, y, acc);
            wait_retire(fov, r, h, fl);
            $display("txn %0d op=%b f=%h a=%h b=%h -> %h_%h flags %b", i, aop, f, x, y, h, r, fl);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
